// File: rtl/gpio_axi_v2_if.sv
// gpio_axi_v2_if: AXI4-Lite bus bundle; master drives requests, slave answers
interface gpio_axi_v2_if;
  logic [31:0] S_AWADDR;
  logic [2:0]  S_AWPROT;
  logic        S_AWVALID;
  logic        S_AWREADY;
  logic [31:0] S_WDATA;
  logic [3:0]  S_WSTRB;
  logic        S_WVALID;
  logic        S_WREADY;
  logic [1:0]  S_BRESP;
  logic        S_BVALID;
  logic        S_BREADY;
  logic [31:0] S_ARADDR;
  logic [2:0]  S_ARPROT;
  logic        S_ARVALID;
  logic        S_ARREADY;
  logic [31:0] S_RDATA;
  logic [1:0]  S_RRESP;
  logic        S_RVALID;
  logic        S_RREADY;
  modport slave (
    input  S_AWADDR, S_AWPROT, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
           S_ARADDR, S_ARPROT, S_ARVALID, S_RREADY,
    output S_AWREADY, S_WREADY, S_BRESP, S_BVALID, S_ARREADY, S_RDATA, S_RRESP, S_RVALID
  );
  modport master (
    output S_AWADDR, S_AWPROT, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
           S_ARADDR, S_ARPROT, S_ARVALID, S_RREADY,
    input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID, S_ARREADY, S_RDATA, S_RRESP, S_RVALID
  );
endinterface

// File: rtl/gpio_axi_v2.sv
// gpio_axi_v2: AXI4-Lite GPIO with set/clear/toggle, input synchronisers and optional pin interrupts
// Ports: aclk, aresetn (async assert, active-low); s (AXI4-Lite slave); gpio_in (async pads);
//   gpio_out (OUT), gpio_oe (DIR, 1 = drive); irq (registered OR of STATUS & EN).
// Define GPIO_AXI_V2_IRQ_EN to build the interrupt block (offsets 0x18..0x2C).
module gpio_axi_v2 #(
  parameter int WIDTH = 32,
  parameter int SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
  input  logic             aclk,
  input  logic             aresetn,
  gpio_axi_v2_if.slave     s,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);
  typedef enum logic [1:0] {W_IDLE, W_WAITW, W_WAITA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;
  w_state_e w_q, w_d;
  r_state_e r_q, r_d;
  logic awready_q, wready_q, arready_q, aw_hs, w_hs, ar_hs, wr, unused_ok;
  logic [31:0] awaddr_q, wdata_q, rdata_q, rdata_d, wa, wd, m;
  logic [3:0] wstrb_q, ws, widx, ridx;
  logic [1:0] bresp_q, rresp_q;
  logic [WIDTH-1:0] dir_q, out_q, out_d, in_s, wv, mv;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
`ifdef GPIO_AXI_V2_IRQ_EN
  logic [WIDTH-1:0] en_q, type_q, pol_q, both_q, status_q, prev_q, rise, fall, ev, w1c;
  logic [2:0] arm_q;
  logic armed, irq_q;
`endif
  assign aw_hs = s.S_AWVALID & awready_q;
  assign w_hs = s.S_WVALID & wready_q;
  assign ar_hs = s.S_ARVALID & arready_q;
  // a handshake landing this cycle is used directly, otherwise the held copy
  assign wa = aw_hs ? s.S_AWADDR : awaddr_q;
  assign wd = w_hs ? s.S_WDATA : wdata_q;
  assign ws = w_hs ? s.S_WSTRB : wstrb_q;
  assign m = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
  assign mv = m[WIDTH-1:0];
  assign wv = wd[WIDTH-1:0] & mv;
  assign widx = wa[5:2];
  assign ridx = s.S_ARADDR[5:2];
  assign in_s = sync_q[SYNC_STAGES-1];
  assign unused_ok = ^{s.S_AWPROT, s.S_ARPROT, wa[31:6], wa[1:0], s.S_ARADDR[31:6], s.S_ARADDR[1:0]};
  always_comb begin
    w_d = w_q;
    case (w_q)
      W_IDLE:  w_d = aw_hs && w_hs ? W_RESP : aw_hs ? W_WAITW : w_hs ? W_WAITA : W_IDLE;
      W_WAITW: w_d = w_hs ? W_RESP : W_WAITW;
      W_WAITA: w_d = aw_hs ? W_RESP : W_WAITA;
      default: w_d = s.S_BREADY ? W_IDLE : W_RESP;
    endcase
  end
  assign r_d = r_q == R_IDLE ? (ar_hs ? R_RESP : R_IDLE) : (s.S_RREADY ? R_IDLE : R_RESP);
  assign wr = w_q != W_RESP && w_d == W_RESP;
  assign out_d = !wr ? out_q : widx == 4'd1 ? (out_q & ~mv) | wv : widx == 4'd3 ? out_q | wv :
                 widx == 4'd4 ? out_q & ~wv : widx == 4'd5 ? out_q ^ wv : out_q;
  always_comb begin
    rdata_d = '0;
    case (ridx)
      4'd0:    rdata_d = 32'(dir_q);
      4'd1:    rdata_d = 32'(out_q);
      4'd2:    rdata_d = 32'(in_s);
`ifdef GPIO_AXI_V2_IRQ_EN
      4'd6:    rdata_d = 32'(en_q);
      4'd7:    rdata_d = 32'(type_q);
      4'd8:    rdata_d = 32'(pol_q);
      4'd9:    rdata_d = 32'(both_q);
      4'd10:   rdata_d = 32'(status_q);
      4'd11:   rdata_d = 32'(status_q & en_q);
`endif
      default: rdata_d = '0;
    endcase
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      w_q <= W_IDLE;
      r_q <= R_IDLE;
      awready_q <= 1'b0;
      wready_q <= 1'b0;
      arready_q <= 1'b0;
      awaddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bresp_q <= '0;
      rresp_q <= '0;
      rdata_q <= '0;
      dir_q <= '0;
      out_q <= OUT_RESET;
      sync_q <= '0;
    end else begin
      w_q <= w_d;
      r_q <= r_d;
      awready_q <= w_d == W_IDLE || w_d == W_WAITA;
      wready_q <= w_d == W_IDLE || w_d == W_WAITW;
      arready_q <= r_d == R_IDLE;
      if (aw_hs) awaddr_q <= s.S_AWADDR;
      if (w_hs) begin
        wdata_q <= s.S_WDATA;
        wstrb_q <= s.S_WSTRB;
      end
      if (wr) bresp_q <= widx >= 4'd12 ? 2'b10 : 2'b00;
      if (ar_hs) begin
        rdata_q <= rdata_d;
        rresp_q <= ridx >= 4'd12 ? 2'b10 : 2'b00;
      end
      dir_q <= wr && widx == 4'd0 ? (dir_q & ~mv) | wv : dir_q;
      out_q <= out_d;
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
    end
`ifdef GPIO_AXI_V2_IRQ_EN
  // edges are ignored until the synchroniser has flushed the zeros it held in reset
  assign armed = arm_q == 3'(SYNC_STAGES + 1);
  assign rise = in_s & ~prev_q;
  assign fall = ~in_s & prev_q;
  assign ev = (type_q & {WIDTH{armed}} & ((both_q & (rise | fall)) | (~both_q & pol_q & rise) |
              (~both_q & ~pol_q & fall))) | (~type_q & ~(pol_q ^ in_s));
  assign w1c = wr && widx == 4'd10 ? wv : '0;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      arm_q <= '0;
      prev_q <= '0;
      en_q <= '0;
      type_q <= '0;
      pol_q <= '0;
      both_q <= '0;
      status_q <= '0;
      irq_q <= 1'b0;
    end else begin
      arm_q <= armed ? arm_q : arm_q + 3'd1;
      prev_q <= in_s;
      en_q <= wr && widx == 4'd6 ? (en_q & ~mv) | wv : en_q;
      type_q <= wr && widx == 4'd7 ? (type_q & ~mv) | wv : type_q;
      pol_q <= wr && widx == 4'd8 ? (pol_q & ~mv) | wv : pol_q;
      both_q <= wr && widx == 4'd9 ? (both_q & ~mv) | wv : both_q;
      status_q <= (status_q & ~w1c) | ev;
      irq_q <= |(status_q & en_q);
    end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif
  assign s.S_AWREADY = awready_q;
  assign s.S_WREADY = wready_q;
  assign s.S_BVALID = w_q == W_RESP;
  assign s.S_BRESP = bresp_q;
  assign s.S_ARREADY = arready_q;
  assign s.S_RVALID = r_q == R_RESP;
  assign s.S_RDATA = rdata_q;
  assign s.S_RRESP = rresp_q;
  assign gpio_out = out_q;
  assign gpio_oe = dir_q;
endmodule
